i2s_stereo_xcvr: RTL and testbench

- Parametrised full-duplex I2S master for the Pmod I2S2 codec path.
- Generates MCLK, SCLK and LRCK from the system clock.
- Serialises a stereo sample pair per frame on the DAC line and deserialises a stereo pair per frame from the ADC line.
- Sits between the audio DSP pipeline (valid/ready sample interface) and the Pmod pins; supports I2S and left-justified framing.

---
 rtl/i2s_pkg.sv | 25 ++
 rtl/i2s_clkgen.sv | 70 +++++++
 rtl/i2s_stereo_xcvr.sv | 159 +++++++++++++++
 tb/tb_i2s_stereo_xcvr.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared types and elaboration-time helpers for the I2S stereo transceiver.
package i2s_pkg;

   typedef enum logic {
      I2S       = 1'b0,
      LEFT_JUST = 1'b1
   } justify_e;

   function automatic int unsigned frame_sclks(int unsigned slot_bits);
      return 2 * slot_bits;
   endfunction

   function automatic int unsigned data_delay(justify_e j);
      return (j == LEFT_JUST) ? 0 : 1;
   endfunction

   // Sample bit index carried at slot position p, or -1 for a padding position.
   function automatic int sample_bit(int p, int sample_width, justify_e j);
      int d;
      d = p - int'(data_delay(j));
      if (d >= 0 && d < sample_width) return sample_width - 1 - d;
      return -1;
   endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// MCLK/SCLK dividers, frame bit counter and LRCK, plus SCLK-fall and frame-start strobes.
module i2s_clkgen
   import i2s_pkg::*;
#(
   parameter  int unsigned SLOT_BITS    = 32,
   parameter  int unsigned CLK_PER_SCLK = 8,
   parameter  int unsigned MCLK_DIV     = 4,
   localparam int unsigned BCW          = $clog2(frame_sclks(SLOT_BITS))
) (
   input  logic           clk,
   input  logic           rst_n,
   output logic           mclk,
   output logic           sclk,
   output logic           lrck,
   output logic [BCW-1:0] bit_cnt,
   output logic [BCW-1:0] bit_cnt_next,
   output logic           fall,
   output logic           frame_start
);

   localparam int unsigned CW = $clog2(CLK_PER_SCLK);
   localparam int unsigned MW = $clog2(MCLK_DIV);

   logic [CW-1:0]  cnt_q, cnt_d;
   logic [MW-1:0]  mcnt_q, mcnt_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d, bit_nxt;
   logic           mclk_q, mclk_d, sclk_q, sclk_d, lrck_q, lrck_d;
   logic           fall_c, wrap_c, mtog_c;

   always_comb begin
      fall_c    = (cnt_q == CW'(CLK_PER_SCLK - 1));
      wrap_c    = (bit_cnt_q == BCW'(frame_sclks(SLOT_BITS) - 1));
      bit_nxt   = wrap_c ? '0 : bit_cnt_q + BCW'(1);
      cnt_d     = fall_c ? '0 : cnt_q + CW'(1);
      // Registered from the next count so sclk falls on the same edge bit_cnt advances.
      sclk_d    = (cnt_d >= CW'(CLK_PER_SCLK / 2));
      bit_cnt_d = fall_c ? bit_nxt : bit_cnt_q;
      lrck_d    = fall_c ? (bit_nxt >= BCW'(SLOT_BITS)) : lrck_q;
      mtog_c    = (mcnt_q == MW'(MCLK_DIV / 2 - 1));
      mcnt_d    = mtog_c ? '0 : mcnt_q + MW'(1);
      mclk_d    = mtog_c ? ~mclk_q : mclk_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         mcnt_q    <= '0;
         bit_cnt_q <= '0;
         mclk_q    <= 1'b0;
         sclk_q    <= 1'b0;
         lrck_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         mcnt_q    <= mcnt_d;
         bit_cnt_q <= bit_cnt_d;
         mclk_q    <= mclk_d;
         sclk_q    <= sclk_d;
         lrck_q    <= lrck_d;
      end
   end

   assign mclk         = mclk_q;
   assign sclk         = sclk_q;
   assign lrck         = lrck_q;
   assign bit_cnt      = bit_cnt_q;
   assign bit_cnt_next = bit_nxt;
   assign fall         = fall_c;
   assign frame_start  = fall_c && wrap_c;

endmodule

// File: rtl/i2s_stereo_xcvr.sv
// Full-duplex I2S / left-justified master: TX holding + frame registers, RX synchroniser
// and per-channel shift registers around the shared clock generator.
module i2s_stereo_xcvr
   import i2s_pkg::*;
#(
   parameter int unsigned SAMPLE_WIDTH = 24,
   parameter int unsigned SLOT_BITS    = 32,
   parameter int unsigned CLK_PER_SCLK = 8,
   parameter int unsigned MCLK_DIV     = 4,
   parameter int unsigned JUSTIFY      = 0
) (
   input  logic                    clk_in,
   input  logic                    rst_n_in,
   input  logic [SAMPLE_WIDTH-1:0] tx_left_in,
   input  logic [SAMPLE_WIDTH-1:0] tx_right_in,
   input  logic                    tx_valid_in,
   output logic                    tx_ready_out,
   output logic                    tx_underrun_out,
   output logic [SAMPLE_WIDTH-1:0] rx_left_out,
   output logic [SAMPLE_WIDTH-1:0] rx_right_out,
   output logic                    rx_valid_out,
   output logic                    mclk_out,
   output logic                    sclk_out,
   output logic                    lrck_out,
   output logic                    sdout_out,
   input  logic                    sdin_in
);

   localparam justify_e    JMODE = (JUSTIFY != 0) ? LEFT_JUST : I2S;
   localparam int unsigned BCW   = $clog2(frame_sclks(SLOT_BITS));

   if (SAMPLE_WIDTH + data_delay(JMODE) > SLOT_BITS) begin : g_chk_width
      $error("SAMPLE_WIDTH plus framing delay bit exceeds SLOT_BITS");
   end
   if (CLK_PER_SCLK < 4 || CLK_PER_SCLK % 2 != 0) begin : g_chk_sclk
      $error("CLK_PER_SCLK must be even and >= 4");
   end
   if (MCLK_DIV < 2 || MCLK_DIV % 2 != 0) begin : g_chk_mclk
      $error("MCLK_DIV must be even and >= 2");
   end

   logic [BCW-1:0] bit_cnt, bit_cnt_next;
   logic           fall, frame_start;

   i2s_clkgen #(
      .SLOT_BITS   (SLOT_BITS),
      .CLK_PER_SCLK(CLK_PER_SCLK),
      .MCLK_DIV    (MCLK_DIV)
   ) u_clkgen (
      .clk         (clk_in),
      .rst_n       (rst_n_in),
      .mclk        (mclk_out),
      .sclk        (sclk_out),
      .lrck        (lrck_out),
      .bit_cnt     (bit_cnt),
      .bit_cnt_next(bit_cnt_next),
      .fall        (fall),
      .frame_start (frame_start)
   );

   logic                    hold_full_q, hold_full_d, transfer;
   logic [SAMPLE_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [SAMPLE_WIDTH-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
   logic [SAMPLE_WIDTH-1:0] tx_word, tx_shift;
   logic                    sdout_q, sdout_d, underrun_q, underrun_d;
   logic                    sync1_q, sync2_q;
   logic [SAMPLE_WIDTH-1:0] rx_sh_l_q, rx_sh_l_d, rx_sh_r_q, rx_sh_r_d;
   logic [SAMPLE_WIDTH-1:0] rx_l_q, rx_l_d, rx_r_q, rx_r_d;
   logic                    rx_done_q, rx_valid_q, rx_valid_d;
   int                      nxt_pos, cur_pos, tx_idx, rx_idx;

   always_comb begin
      transfer    = tx_valid_in && !hold_full_q;
      hold_full_d = hold_full_q;
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      frame_l_d   = frame_l_q;
      frame_r_d   = frame_r_q;
      if (frame_start) begin
         frame_l_d   = hold_full_q ? hold_l_q : '0;
         frame_r_d   = hold_full_q ? hold_r_q : '0;
         hold_full_d = 1'b0;
      end
      // A pair accepted on the frame-start cycle waits in holding for the next frame.
      if (transfer) begin
         hold_full_d = 1'b1;
         hold_l_d    = tx_left_in;
         hold_r_d    = tx_right_in;
      end
      underrun_d = frame_start && !hold_full_q;

      // sdout is registered, so it is driven for the position being entered.
      nxt_pos  = int'(bit_cnt_next) % int'(SLOT_BITS);
      tx_idx   = sample_bit(nxt_pos, int'(SAMPLE_WIDTH), JMODE);
      tx_word  = (bit_cnt_next >= BCW'(SLOT_BITS)) ? frame_r_d : frame_l_d;
      tx_shift = (tx_idx >= 0) ? (tx_word >> tx_idx) : '0;
      sdout_d  = fall ? tx_shift[0] : sdout_q;

      // Capture happens for the position being left, late in its SCLK high phase.
      cur_pos   = int'(bit_cnt) % int'(SLOT_BITS);
      rx_idx    = sample_bit(cur_pos, int'(SAMPLE_WIDTH), JMODE);
      rx_sh_l_d = rx_sh_l_q;
      rx_sh_r_d = rx_sh_r_q;
      if (fall && rx_idx >= 0) begin
         if (bit_cnt >= BCW'(SLOT_BITS)) begin
            rx_sh_r_d = (rx_sh_r_q << 1) | SAMPLE_WIDTH'(sync2_q);
         end else begin
            rx_sh_l_d = (rx_sh_l_q << 1) | SAMPLE_WIDTH'(sync2_q);
         end
      end
      rx_l_d     = rx_done_q ? rx_sh_l_q : rx_l_q;
      rx_r_d     = rx_done_q ? rx_sh_r_q : rx_r_q;
      rx_valid_d = rx_done_q;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         hold_full_q <= 1'b0;
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         frame_l_q   <= '0;
         frame_r_q   <= '0;
         sdout_q     <= 1'b0;
         underrun_q  <= 1'b0;
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         rx_sh_l_q   <= '0;
         rx_sh_r_q   <= '0;
         rx_l_q      <= '0;
         rx_r_q      <= '0;
         rx_done_q   <= 1'b0;
         rx_valid_q  <= 1'b0;
      end else begin
         hold_full_q <= hold_full_d;
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         frame_l_q   <= frame_l_d;
         frame_r_q   <= frame_r_d;
         sdout_q     <= sdout_d;
         underrun_q  <= underrun_d;
         sync1_q     <= sdin_in;
         sync2_q     <= sync1_q;
         rx_sh_l_q   <= rx_sh_l_d;
         rx_sh_r_q   <= rx_sh_r_d;
         rx_l_q      <= rx_l_d;
         rx_r_q      <= rx_r_d;
         rx_done_q   <= frame_start;
         rx_valid_q  <= rx_valid_d;
      end
   end

   assign tx_ready_out    = !hold_full_q;
   assign tx_underrun_out = underrun_q;
   assign sdout_out       = sdout_q;
   assign rx_left_out     = rx_l_q;
   assign rx_right_out    = rx_r_q;
   assign rx_valid_out    = rx_valid_q;

endmodule

// File: tb/tb_i2s_stereo_xcvr.sv
// Loopback bench for three transceiver configurations: per-cycle pin model plus an RX
// scoreboard fed with the pair each frame is expected to carry.
module tb_i2s_stereo_xcvr;

   localparam int NDUT = 3;
   localparam int P_W   [NDUT] = '{24, 24, 16};
   localparam int P_S   [NDUT] = '{32, 32, 16};
   localparam int P_CPS [NDUT] = '{8, 8, 4};
   localparam int P_MD  [NDUT] = '{4, 4, 2};
   localparam int P_J   [NDUT] = '{0, 1, 1};
   localparam logic [23:0] DIR_L [NDUT] = '{24'hABCDEF, 24'h800001, 24'h00BEEF};
   localparam logic [23:0] DIR_R [NDUT] = '{24'h123456, 24'h7FFFFE, 24'h000F0F};

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   task automatic check(input string name, input int g, input logic [63:0] act,
                        input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s dut%0d @%0t: got %h expected %h", name, g, $time, act, exp);
      end
   endtask

   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      localparam int W     = P_W[g];
      localparam int S     = P_S[g];
      localparam int CPS   = P_CPS[g];
      localparam int MD    = P_MD[g];
      localparam int J     = P_J[g];
      localparam int FRAME = 2 * S * CPS;
      localparam int HALF  = MD / 2;
      localparam int DL    = (J != 0) ? 0 : 1;

      logic [W-1:0] txl, txr, rxl, rxr;
      logic         txv, txrdy, unr, rxv, mclk, sclk, lrck, sd;

      i2s_stereo_xcvr #(
         .SAMPLE_WIDTH(W),
         .SLOT_BITS   (S),
         .CLK_PER_SCLK(CPS),
         .MCLK_DIV    (MD),
         .JUSTIFY     (J)
      ) u_dut (
         .clk_in         (clk),
         .rst_n_in       (rst_n),
         .tx_left_in     (txl),
         .tx_right_in    (txr),
         .tx_valid_in    (txv),
         .tx_ready_out   (txrdy),
         .tx_underrun_out(unr),
         .rx_left_out    (rxl),
         .rx_right_out   (rxr),
         .rx_valid_out   (rxv),
         .mclk_out       (mclk),
         .sclk_out       (sclk),
         .lrck_out       (lrck),
         .sdout_out      (sd),
         .sdin_in        (sd)
      );

      int             t;
      bit             hold_full;
      bit             exp_unr;
      logic [W-1:0]   hold_l, hold_r, fr_l, fr_r;
      logic [2*W-1:0] exp_q[$];

      // Expected serial bit once t edges have elapsed since reset release.
      function automatic logic exp_bit(int tt, logic [W-1:0] l, logic [W-1:0] r);
         int           bc, d;
         logic [W-1:0] word;
         bc = (tt / CPS) % (2 * S);
         d  = (bc % S) - DL;
         if (d < 0 || d >= W) return 1'b0;
         word = (bc >= S) ? r : l;
         word = word >> (W - 1 - d);
         return word[0];
      endfunction

      // Stimulus and reference model; expected pins are recomputed from t each cycle.
      initial begin : model
         logic [6:0] got, want;
         bit         xfer, fs, dir_sent;
         int         f;
         t = 0; hold_full = 0; exp_unr = 0; dir_sent = 0;
         hold_l = '0; hold_r = '0; fr_l = '0; fr_r = '0;
         txv = 1'b0; txl = '0; txr = '0;
         exp_q.delete();
         exp_q.push_back((2 * W)'(0));
         xfer = 0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               t = 0; hold_full = 0; exp_unr = 0; xfer = 0;
               fr_l = '0; fr_r = '0;
               exp_q.delete();
               exp_q.push_back((2 * W)'(0));
               check("reset_rx", g, 64'({rxl, rxr}), 64'(0));
            end else begin
               t++;
               xfer    = txv && !hold_full;
               fs      = (t % FRAME) == 0;
               exp_unr = fs && !hold_full;
               if (fs) begin
                  fr_l      = hold_full ? hold_l : '0;
                  fr_r      = hold_full ? hold_r : '0;
                  hold_full = 0;
                  exp_q.push_back({fr_l, fr_r});
               end
               if (xfer) begin
                  hold_full = 1; hold_l = txl; hold_r = txr;
               end
            end
            want = {((t / HALF) % 2) == 1, (t % CPS) >= CPS / 2, ((t / CPS) % (2 * S)) >= S,
                    exp_bit(t, fr_l, fr_r), !hold_full, exp_unr,
                    (t % FRAME) == 1 && t > FRAME};
            got  = {mclk, sclk, lrck, sd, txrdy, unr, rxv};
            check("pins{mclk,sclk,lrck,sdout,rdy,unr,rxv}", g, 64'(got), 64'(want));

            f = t / FRAME;
            if (!rst_n) begin
               txv = 1'b0;
            end else if (f < 4) begin
               // Valid held high: a new pair is presented only after each accept.
               if (xfer || !txv) begin
                  txv = 1'b1;
                  if (!dir_sent) begin
                     txl = W'(DIR_L[g]); txr = W'(DIR_R[g]); dir_sent = 1;
                  end else begin
                     txl = W'($urandom); txr = W'($urandom);
                  end
               end
            end else if (f < 7) begin
               txv = 1'b0; txl = W'($urandom); txr = W'($urandom);
            end else begin
               if (!txv || xfer) txv = ($urandom_range(0, 3) == 0);
               txl = W'($urandom); txr = W'($urandom);
            end
         end
      end

      initial begin : monitor
         logic [2*W-1:0] e;
         forever begin
            @(negedge clk);
            if (rst_n && rxv) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL rx_pair dut%0d @%0t: got %h expected no pair", g, $time,
                           {rxl, rxr});
               end else begin
                  e = exp_q.pop_front();
                  check("rx_pair", g, 64'({rxl, rxr}), 64'(e));
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (5320) @(negedge clk);
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (2600) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
